pe_noc_endpoint: RTL and testbench

PE-side endpoint for one HNoC port; it is the other end of the port handshake from the network. The transmitter injects a programmable burst of sequence-numbered flits, rotating the destination across all other PEs. The receiver accepts flits from the network and checks the destination field and per-source sequence order. It is used as the traffic source/sink on each PE port for bring-up and stress testing.

---
 rtl/pe_noc_endpoint.sv | 221 ++++++++++++++++++++++
 tb/tb_pe_noc_endpoint.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_noc_endpoint.sv
// PE-side endpoint for one HNoC port.
// TX: injects a burst of NumPkts sequence-numbered flits, rotating the
//     destination over every other PE and keeping a sequence counter per
//     destination.
// RX: accepts flits from the network, checks the destination and the
//     per-source sequence order, and counts flits and errors (saturating).
// Flit layout: {dest[AddrWidth], src[AddrWidth], seq[DataWidth-AddrWidth]}.
module pe_noc_endpoint #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 3,
   parameter int NumPE     = 8,
   parameter int PeId      = 0,
   parameter int NumPkts   = 16
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic                           i_rx_stall,
   output logic [DataWidth+AddrWidth-1:0] o_pe_data,
   output logic                           o_pe_data_valid,
   input  logic                           i_pe_data_ready,
   input  logic [DataWidth+AddrWidth-1:0] i_pe_data,
   input  logic                           i_pe_data_valid,
   output logic                           o_pe_data_ready,
   output logic                           o_busy,
   output logic                           o_done,
   output logic [15:0]                    o_tx_count,
   output logic [15:0]                    o_rx_count,
   output logic [15:0]                    o_err_count
);

   localparam int FlitWidth = DataWidth + AddrWidth;
   localparam int SeqWidth  = DataWidth - AddrWidth;
   // Tables are sized to the full address space so that an out-of-range
   // source address still indexes a real entry when it is looked up.
   localparam int NumSlots  = 2 ** AddrWidth;

   localparam logic [AddrWidth-1:0] PE_ADDR    = AddrWidth'(PeId);
   localparam logic [AddrWidth-1:0] LAST_PE    = AddrWidth'(NumPE - 1);
   localparam logic [AddrWidth-1:0] DEST_INIT  = AddrWidth'((PeId + 1) % NumPE);
   localparam logic [AddrWidth:0]   NUM_PE_EXT = (AddrWidth + 1)'(NumPE);
   localparam logic [15:0]          LAST_COUNT = 16'(NumPkts - 1);
   localparam logic [15:0]          SAT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_t;

   // Next destination in the rotation: increment modulo NumPE, stepping
   // over our own address so the endpoint never sends to itself.
   function automatic logic [AddrWidth-1:0] next_dest(input logic [AddrWidth-1:0] d);
      logic [AddrWidth-1:0] n;
      n = (d == LAST_PE) ? '0 : d + AddrWidth'(1);
      if (n == PE_ADDR) begin
         n = (n == LAST_PE) ? '0 : n + AddrWidth'(1);
      end
      return n;
   endfunction

   // ------------------------------------------------------------------
   // TX state
   // ------------------------------------------------------------------
   tx_state_t               state_q;
   tx_state_t               state_d;
   logic                    start_burst;
   logic                    finish_burst;
   logic                    tx_fire;
   logic                    last_flit;

   logic [AddrWidth-1:0]    dest_q;
   logic [AddrWidth-1:0]    dest_nxt;
   logic [SeqWidth-1:0]     seq_nxt;
   logic [SeqWidth-1:0]     tx_seq_q [NumSlots];
   logic [15:0]             tx_count_q;
   logic [FlitWidth-1:0]    tx_data_q;

   // Valid is purely a function of the state register, never of ready.
   assign tx_fire   = (state_q == SEND) && i_pe_data_ready;
   assign last_flit = (tx_count_q == LAST_COUNT);
   assign dest_nxt  = next_dest(dest_q);
   // With only two PEs the rotation returns to the same destination, so the
   // following flit must already see that destination's incremented seq.
   assign seq_nxt   = (dest_nxt == dest_q) ? tx_seq_q[dest_q] + SeqWidth'(1)
                                           : tx_seq_q[dest_nxt];

   // TX state register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
      end else begin
         // NOTE: clocked state is updated with <= so every register samples
         // pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   // TX next-state logic and burst control strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      start_burst  = 1'b0;
      finish_burst = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               state_d     = SEND;
               start_burst = 1'b1;
            end
         end
         SEND: begin
            // i_start is deliberately ignored while a burst is running.
            if (tx_fire && last_flit) begin
               state_d      = DONE;
               finish_burst = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // TX datapath: destination pointer, per-destination seq table, flit
   // register and burst counter.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         dest_q     <= DEST_INIT;
         tx_count_q <= '0;
         tx_data_q  <= '0;
         // NOTE: the seq table is architecturally cleared by reset, so this
         // small memory is built from resettable flops rather than a RAM.
         for (int i = 0; i < NumSlots; i++) begin
            tx_seq_q[i] <= '0;
         end
      end else if (start_burst) begin
         // The pointer carries on from the previous burst.
         tx_count_q <= '0;
         tx_data_q  <= {dest_q, PE_ADDR, tx_seq_q[dest_q]};
      end else if (tx_fire) begin
         tx_seq_q[dest_q] <= tx_seq_q[dest_q] + SeqWidth'(1);
         tx_count_q       <= tx_count_q + 16'd1;
         dest_q           <= dest_nxt;
         // Preload the following flit so back-to-back transfers need no
         // bubble; on the final flit the value is simply never presented.
         tx_data_q        <= {dest_nxt, PE_ADDR, seq_nxt};
      end
   end

   // finish_burst is fully captured by the DONE state; keep it observable
   // for debug without a separate register.
   logic unused_finish;
   assign unused_finish = finish_burst;

   assign o_pe_data       = tx_data_q;
   assign o_pe_data_valid = (state_q == SEND);
   assign o_busy          = (state_q == SEND);
   assign o_done          = (state_q == DONE);
   assign o_tx_count      = tx_count_q;

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   logic                    rx_ready_q;
   logic                    rx_fire;
   logic [AddrWidth-1:0]    rx_dest;
   logic [AddrWidth-1:0]    rx_src;
   logic [SeqWidth-1:0]     rx_seq;
   logic                    rx_src_ok;
   logic                    rx_err;
   logic [SeqWidth-1:0]     rx_exp_q [NumSlots];
   logic [15:0]             rx_count_q;
   logic [15:0]             err_count_q;

   assign rx_dest   = i_pe_data[FlitWidth-1 -: AddrWidth];
   assign rx_src    = i_pe_data[DataWidth-1 -: AddrWidth];
   assign rx_seq    = i_pe_data[SeqWidth-1:0];
   assign rx_src_ok = ({1'b0, rx_src} < NUM_PE_EXT);
   assign rx_fire   = i_pe_data_valid && rx_ready_q;
   assign rx_err    = (rx_dest != PE_ADDR) || !rx_src_ok ||
                      (rx_seq != rx_exp_q[rx_src]);

   // RX ready register: follows the stall input one cycle later.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_ready_q <= 1'b0;
      end else begin
         rx_ready_q <= !i_rx_stall;
      end
   end

   // RX checker: expected-seq table and saturating flit/error counters.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_count_q  <= '0;
         err_count_q <= '0;
         for (int i = 0; i < NumSlots; i++) begin
            rx_exp_q[i] <= '0;
         end
      end else if (rx_fire) begin
         if (rx_count_q != SAT_MAX) begin
            rx_count_q <= rx_count_q + 16'd1;
         end
         if (rx_err && (err_count_q != SAT_MAX)) begin
            err_count_q <= err_count_q + 16'd1;
         end
         // Resynchronise on whatever arrived so one lost flit costs a single
         // error rather than an error on every later flit from that source.
         if (rx_src_ok) begin
            rx_exp_q[rx_src] <= rx_seq + SeqWidth'(1);
         end
      end
   end

   assign o_pe_data_ready = rx_ready_q;
   assign o_rx_count      = rx_count_q;
   assign o_err_count     = err_count_q;

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// Testbench for pe_noc_endpoint (PeId=2, NumPE=8, NumPkts=8).
// Directed RX vector table, hand-written TX burst/backpressure/reset
// sequences, then randomized traffic against a burst-level reference model.
module tb_pe_noc_endpoint;

   localparam int DW  = 32;
   localparam int AW  = 3;
   localparam int NPE = 8;
   localparam int PE  = 2;
   localparam int NPK = 8;
   localparam int FW  = DW + AW;
   localparam int SW  = DW - AW;

   logic          i_clk;
   logic          i_reset;
   logic          i_start;
   logic          i_rx_stall;
   logic [FW-1:0] o_pe_data;
   logic          o_pe_data_valid;
   logic          i_pe_data_ready;
   logic [FW-1:0] i_pe_data;
   logic          i_pe_data_valid;
   logic          o_pe_data_ready;
   logic          o_busy;
   logic          o_done;
   logic [15:0]   o_tx_count;
   logic [15:0]   o_rx_count;
   logic [15:0]   o_err_count;

   pe_noc_endpoint #(
      .DataWidth(DW), .AddrWidth(AW), .NumPE(NPE), .PeId(PE), .NumPkts(NPK)
   ) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_start         (i_start),
      .i_rx_stall      (i_rx_stall),
      .o_pe_data       (o_pe_data),
      .o_pe_data_valid (o_pe_data_valid),
      .i_pe_data_ready (i_pe_data_ready),
      .i_pe_data       (i_pe_data),
      .i_pe_data_valid (i_pe_data_valid),
      .o_pe_data_ready (o_pe_data_ready),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_tx_count      (o_tx_count),
      .o_rx_count      (o_rx_count),
      .o_err_count     (o_err_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [FW-1:0] mk(input int d, input int s, input logic [SW-1:0] q);
      return {3'(d), 3'(s), q};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  o_pe_data,       '0);
      check({tag, "_valid"}, o_pe_data_valid, 0);
      check({tag, "_ready"}, o_pe_data_ready, 0);
      check({tag, "_busy"},  o_busy,          0);
      check({tag, "_done"},  o_done,          0);
      check({tag, "_txc"},   o_tx_count,      0);
      check({tag, "_rxc"},   o_rx_count,      0);
      check({tag, "_errc"},  o_err_count,     0);
   endtask

   // ---------------- RX vector table ----------------
   typedef struct {
      logic [2:0]    dest;
      logic [2:0]    src;
      logic [SW-1:0] seq;
      logic          stall;
      logic [15:0]   exp_rx;
      logic [15:0]   exp_err;
   } rx_vec_t;

   rx_vec_t vecs [10];

   // ---------------- reference model state ----------------
   logic [SW-1:0] m_tx_seq [NPE];
   logic [SW-1:0] m_rx_exp [NPE];
   int            m_ptr;
   logic [FW-1:0] m_txq [$];
   logic          m_busy, m_done, m_ready;
   logic [15:0]   m_txc, m_rxc, m_errc;

   task automatic model_reset();
      for (int i = 0; i < NPE; i++) begin
         m_tx_seq[i] = '0;
         m_rx_exp[i] = '0;
      end
      m_ptr   = (PE + 1) % NPE;
      m_txq.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_ready = 1'b1;
      m_txc   = '0;
      m_rxc   = '0;
      m_errc  = '0;
   endtask

   // Whole burst is precomputed when it is accepted.
   task automatic model_start_burst();
      for (int k = 0; k < NPK; k++) begin
         m_txq.push_back(mk(m_ptr, PE, m_tx_seq[m_ptr]));
         m_tx_seq[m_ptr] = m_tx_seq[m_ptr] + 1'b1;
         m_ptr = (m_ptr + 1) % NPE;
         if (m_ptr == PE) m_ptr = (m_ptr + 1) % NPE;
      end
      m_busy = 1'b1;
      m_done = 1'b0;
      m_txc  = '0;
   endtask

   task automatic rand_cycle();
      logic          start_pre, rdy_pre, rxv_pre, stall_pre;
      logic [FW-1:0] rxd_pre;
      int            d, s;
      logic [SW-1:0] q;
      logic          bad;
      // new random inputs
      i_start         = ($urandom_range(0, 9) == 0);
      i_pe_data_ready = ($urandom_range(0, 3) != 0);
      i_rx_stall      = ($urandom_range(0, 4) == 0);
      i_pe_data_valid = $urandom_range(0, 1);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NPE - 1) : PE;
      s = $urandom_range(0, NPE - 1);
      q = ($urandom_range(0, 9) < 7) ? m_rx_exp[s] : SW'($urandom_range(0, 7));
      i_pe_data = mk(d, s, q);
      start_pre = i_start;
      rdy_pre   = i_pe_data_ready;
      rxv_pre   = i_pe_data_valid;
      stall_pre = i_rx_stall;
      rxd_pre   = i_pe_data;
      step();
      // TX model
      if (m_busy && rdy_pre) begin
         void'(m_txq.pop_front());
         m_txc = m_txc + 16'd1;
         if (m_txq.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end else if (!m_busy && start_pre) begin
         model_start_burst();
      end
      // RX model
      if (rxv_pre && m_ready) begin
         d = int'(rxd_pre[FW-1 -: AW]);
         s = int'(rxd_pre[DW-1 -: AW]);
         q = rxd_pre[SW-1:0];
         bad = (d != PE) || (s >= NPE) || (q != m_rx_exp[s]);
         if (m_rxc != 16'hFFFF) m_rxc = m_rxc + 16'd1;
         if (bad && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
         if (s < NPE) m_rx_exp[s] = q + 1'b1;
      end
      m_ready = !stall_pre;
      check("rnd_valid", o_pe_data_valid, m_busy);
      check("rnd_busy",  o_busy,          m_busy);
      check("rnd_done",  o_done,          m_done);
      check("rnd_txc",   o_tx_count,      m_txc);
      check("rnd_ready", o_pe_data_ready, m_ready);
      check("rnd_rxc",   o_rx_count,      m_rxc);
      check("rnd_errc",  o_err_count,     m_errc);
      if (m_busy) check("rnd_data", o_pe_data, m_txq[0]);
   endtask

   int exp1_dest [8] = '{3, 4, 5, 6, 7, 0, 1, 3};
   int exp1_seq  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
   int exp2_dest [8] = '{4, 5, 6, 7, 0, 1, 3, 4};
   int exp2_seq  [8] = '{1, 1, 1, 1, 1, 1, 2, 2};

   initial begin
      vecs[0] = '{3'd2, 3'd5, 29'd0, 1'b0, 16'd1, 16'd0};
      vecs[1] = '{3'd2, 3'd5, 29'd1, 1'b0, 16'd2, 16'd0};
      vecs[2] = '{3'd2, 3'd5, 29'd2, 1'b0, 16'd3, 16'd0};
      vecs[3] = '{3'd2, 3'd6, 29'd0, 1'b0, 16'd4, 16'd0};
      vecs[4] = '{3'd2, 3'd6, 29'd2, 1'b0, 16'd5, 16'd1};
      vecs[5] = '{3'd2, 3'd6, 29'd3, 1'b0, 16'd6, 16'd1};
      vecs[6] = '{3'd4, 3'd6, 29'd4, 1'b0, 16'd7, 16'd2};
      vecs[7] = '{3'd2, 3'd6, 29'd5, 1'b1, 16'd7, 16'd2};
      vecs[8] = '{3'd2, 3'd6, 29'd5, 1'b0, 16'd8, 16'd2};
      vecs[9] = '{3'd2, 3'd0, 29'd1, 1'b0, 16'd9, 16'd3};

      i_reset         = 1'b0;
      i_start         = 1'b0;
      i_rx_stall      = 1'b0;
      i_pe_data_ready = 1'b1;
      i_pe_data       = '0;
      i_pe_data_valid = 1'b0;

      // ---- reset state ----
      repeat (3) step();
      check_all_zero("rst");
      i_reset = 1'b1;
      check("rst_rel_ready0", o_pe_data_ready, 0);
      step();
      check("rst_rel_ready1", o_pe_data_ready, 1);

      // ---- RX vector table ----
      for (int i = 0; i < 10; i++) begin
         i_rx_stall = vecs[i].stall;
         step();
         check($sformatf("rxv%0d_ready", i), o_pe_data_ready, !vecs[i].stall);
         i_pe_data       = mk(vecs[i].dest, vecs[i].src, vecs[i].seq);
         i_pe_data_valid = 1'b1;
         step();
         i_pe_data_valid = 1'b0;
         check($sformatf("rxv%0d_rxc", i), o_rx_count,  vecs[i].exp_rx);
         check($sformatf("rxv%0d_err", i), o_err_count, vecs[i].exp_err);
      end
      i_rx_stall = 1'b0;

      // ---- burst 1: ready tied high ----
      i_pe_data_ready = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      check("b1_busy", o_busy, 1);
      check("b1_done", o_done, 0);
      for (int k = 0; k < NPK; k++) begin
         check($sformatf("b1_valid%0d", k), o_pe_data_valid, 1);
         check($sformatf("b1_data%0d", k),  o_pe_data, mk(exp1_dest[k], PE, SW'(exp1_seq[k])));
         check($sformatf("b1_txc%0d", k),   o_tx_count, 16'(k));
         step();
      end
      check("b1_end_valid", o_pe_data_valid, 0);
      check("b1_end_done",  o_done, 1);
      check("b1_end_busy",  o_busy, 0);
      check("b1_end_txc",   o_tx_count, 16'd8);

      // ---- burst 2: from DONE, backpressure, ignored start ----
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      check("b2_txc0",  o_tx_count, 16'd0);
      check("b2_done0", o_done, 0);
      for (int k = 0; k < NPK; k++) begin
         check($sformatf("b2_valid%0d", k), o_pe_data_valid, 1);
         check($sformatf("b2_data%0d", k),  o_pe_data, mk(exp2_dest[k], PE, SW'(exp2_seq[k])));
         check($sformatf("b2_txc%0d", k),   o_tx_count, 16'(k));
         if (k == 2) begin
            i_pe_data_ready = 1'b0;
            repeat (5) begin
               step();
               check("b2_hold_valid", o_pe_data_valid, 1);
               check("b2_hold_data",  o_pe_data, mk(exp2_dest[2], PE, SW'(exp2_seq[2])));
               check("b2_hold_txc",   o_tx_count, 16'd2);
            end
            i_pe_data_ready = 1'b1;
         end
         if (k == 4) i_start = 1'b1;
         step();
         i_start = 1'b0;
      end
      check("b2_end_valid", o_pe_data_valid, 0);
      check("b2_end_done",  o_done, 1);
      check("b2_end_txc",   o_tx_count, 16'd8);
      step();
      check("b2_stay_done", o_done, 1);

      // ---- burst 3: reset mid-burst ----
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      step();
      step();
      check("b3_mid_busy", o_busy, 1);
      #2;
      i_reset = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      i_reset = 1'b1;
      check("midrst_rel_ready0", o_pe_data_ready, 0);
      step();
      check("midrst_rel_ready1", o_pe_data_ready, 1);
      check("midrst_rel_valid",  o_pe_data_valid, 0);
      step();

      // ---- randomized traffic vs reference model ----
      model_reset();
      for (int c = 0; c < 3000; c++) rand_cycle();
      // drain any burst in flight, bounded
      for (int c = 0; c < 40 && m_busy; c++) begin
         rand_cycle();
         i_pe_data_ready = 1'b1;
      end
      check("drain_done", m_busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
